// File: rtl/insn_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode bit positions,
// legal-opcode mask, FSM state encoding and fault codes.
package dpc_pkg;

    localparam int OPCODE_W = 16;

    // One-hot opcode bit positions
    localparam int OP_NOP        = 0;
    localparam int OP_HALT       = 1;
    localparam int OP_PLUS       = 2;
    localparam int OP_MINUS      = 3;
    localparam int OP_RIGHT      = 4;
    localparam int OP_LOOP_OPEN  = 5;
    localparam int OP_LOOP_CLOSE = 6;
    localparam int OP_LEFT       = 7;
    localparam int OP_OUT        = 8;
    localparam int OP_IN         = 9;

    // Bits 10..15 are reserved; any of them set makes the opcode illegal
    localparam logic [OPCODE_W-1:0] LEGAL_MASK = 16'h03FF;

    // HALT and FAULT share one encoding; Halted/Fault tell them apart
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_OP   = 3'd1,
        S_DISPATCH  = 3'd2,
        S_GUARD     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_ACK       = 3'd5,
        S_DRAIN     = 3'd6,
        S_STOP      = 3'd7
    } seq_state_t;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

endpackage

// File: rtl/insn_sequencer_if.sv
// Handshake and unit-control bundle between the sequencer (master) and
// the instruction pipeline / execution units (slave).
interface insn_sequencer_if #(
    parameter int OPCODE_W = 16
);
    logic                Run;
    logic                Step;
    logic [OPCODE_W-1:0] Opcode;
    logic                OpcodeReady;
    logic                OpcodeAck;
    logic                ApInc;
    logic                ApDec;
    logic                ApReady;
    logic                DataInc;
    logic                DataDec;
    logic                DataReady;
    logic                IoOutReq;
    logic                IoInReq;
    logic                IoAck;
    logic                Halted;
    logic                Fault;
    logic [1:0]          FaultCode;
    logic [2:0]          State;

    modport master (
        input  Run, Step, Opcode, OpcodeReady, ApReady, DataReady, IoAck,
        output OpcodeAck, ApInc, ApDec, DataInc, DataDec, IoOutReq, IoInReq,
               Halted, Fault, FaultCode, State
    );

    modport slave (
        output Run, Step, Opcode, OpcodeReady, ApReady, DataReady, IoAck,
        input  OpcodeAck, ApInc, ApDec, DataInc, DataDec, IoOutReq, IoInReq,
               Halted, Fault, FaultCode, State
    );
endinterface

// File: rtl/insn_sequencer_busy_watchdog.sv
// Saturating busy-cycle counter; flags expiry once a counter unit has been
// busy for TIMEOUT consecutive enabled cycles.
module busy_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up while enabled and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + TO_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q >= LIMIT);

endmodule

// File: rtl/insn_sequencer.sv
// Execution controller: takes one one-hot opcode at a time from the IP line,
// strobes the matching execution unit, waits for completion and acknowledges.
module insn_sequencer #(
    parameter int OPCODE_W = 16,
    parameter int TIMEOUT  = 1024,
    parameter int TO_W     = 11
) (
    input logic              Clk,
    input logic              Rst,
    insn_sequencer_if.master bus
);
    import dpc_pkg::*;

    seq_state_t          state_q;
    logic [OPCODE_W-1:0] op_q;
    logic                step_pending_q;
    logic                ack_q;
    logic                ap_inc_q, ap_dec_q, data_inc_q, data_dec_q;
    logic                io_out_q, io_in_q;
    logic                halted_q, fault_q;
    logic [1:0]          fault_code_q;

    logic op_data, op_ap, op_io, unit_ready;
    logic wd_clear, wd_enable, wd_expired;

    // Exactly one bit set, and that bit is not a reserved one
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        logic [OPCODE_W-1:0] mask;
        mask = OPCODE_W'(LEGAL_MASK);
        return (op != '0) && ((op & (op - OPCODE_W'(1))) == '0) && ((op & ~mask) == '0);
    endfunction

    assign op_data    = op_q[OP_PLUS] | op_q[OP_MINUS];
    assign op_ap      = op_q[OP_RIGHT] | op_q[OP_LEFT];
    assign op_io      = op_q[OP_OUT] | op_q[OP_IN];
    assign unit_ready = op_data ? bus.DataReady : bus.ApReady;

    // Watchdog runs across GUARD and the counter-unit wait; IO waits are unbounded
    assign wd_clear  = (state_q == S_DISPATCH);
    assign wd_enable = (state_q == S_GUARD) || ((state_q == S_WAIT_DONE) && !op_io);

    busy_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Sequencer FSM with registered strobes, requests and status
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            step_pending_q <= 1'b0;
            ack_q          <= 1'b0;
            ap_inc_q       <= 1'b0;
            ap_dec_q       <= 1'b0;
            data_inc_q     <= 1'b0;
            data_dec_q     <= 1'b0;
            io_out_q       <= 1'b0;
            io_in_q        <= 1'b0;
            halted_q       <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= FAULT_NONE;
        end else begin
            // Unit strobes and the ack are single-cycle pulses
            ack_q      <= 1'b0;
            ap_inc_q   <= 1'b0;
            ap_dec_q   <= 1'b0;
            data_inc_q <= 1'b0;
            data_dec_q <= 1'b0;

            // Step only arms single-step mode; with Run high it is dropped
            if ((state_q != S_STOP) && bus.Step && !bus.Run) begin
                step_pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: state_q <= S_WAIT_OP;

                S_WAIT_OP: begin
                    if (bus.OpcodeReady && (bus.Run || step_pending_q)) begin
                        op_q           <= bus.Opcode;
                        step_pending_q <= 1'b0;
                        state_q        <= S_DISPATCH;
                        // Strobes are launched so they are high during DISPATCH
                        if (is_legal(bus.Opcode)) begin
                            data_inc_q <= bus.Opcode[OP_PLUS];
                            data_dec_q <= bus.Opcode[OP_MINUS];
                            ap_inc_q   <= bus.Opcode[OP_RIGHT];
                            ap_dec_q   <= bus.Opcode[OP_LEFT];
                            io_out_q   <= bus.Opcode[OP_OUT];
                            io_in_q    <= bus.Opcode[OP_IN];
                        end
                    end
                end

                S_DISPATCH: begin
                    if (!is_legal(op_q)) begin
                        fault_q      <= 1'b1;
                        fault_code_q <= FAULT_ILLEGAL;
                        state_q      <= S_STOP;
                    end else if (op_q[OP_HALT]) begin
                        halted_q <= 1'b1;
                        ack_q    <= 1'b1;
                        state_q  <= S_STOP;
                    end else if (op_data || op_ap) begin
                        state_q <= S_GUARD;
                    end else if (op_io) begin
                        state_q <= S_WAIT_DONE;
                    end else begin
                        // NOP and loop brackets complete without a unit
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end

                // Unit Ready may still show idle this cycle; ignore it
                S_GUARD: state_q <= S_WAIT_DONE;

                S_WAIT_DONE: begin
                    if (op_io) begin
                        if (bus.IoAck) begin
                            io_out_q <= 1'b0;
                            io_in_q  <= 1'b0;
                            ack_q    <= 1'b1;
                            state_q  <= S_ACK;
                        end
                    end else if (unit_ready) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else if (wd_expired) begin
                        fault_q      <= 1'b1;
                        fault_code_q <= FAULT_TIMEOUT;
                        state_q      <= S_STOP;
                    end
                end

                S_ACK: state_q <= S_DRAIN;

                // Hold off until the IP line withdraws the consumed opcode
                S_DRAIN: begin
                    if (!bus.OpcodeReady) begin
                        state_q <= S_WAIT_OP;
                    end
                end

                S_STOP: state_q <= S_STOP;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.OpcodeAck = ack_q;
    assign bus.ApInc     = ap_inc_q;
    assign bus.ApDec     = ap_dec_q;
    assign bus.DataInc   = data_inc_q;
    assign bus.DataDec   = data_dec_q;
    assign bus.IoOutReq  = io_out_q;
    assign bus.IoInReq   = io_in_q;
    assign bus.Halted    = halted_q;
    assign bus.Fault     = fault_q;
    assign bus.FaultCode = fault_code_q;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Bench for insn_sequencer: behavioural IP-line and execution-unit models,
// transaction-level expectations derived from the opcode rules.
module tb_insn_sequencer;

    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Per-transaction observation counters
    int n_dinc, n_ddec, n_ainc, n_adec, n_out, n_in, n_ack;
    int ack_cyc, strobe_cyc;

    // Unit model state
    int data_busy, ap_busy, data_lat, ap_lat, io_lat, io_cnt;

    int legal_ops[9] = '{0, 2, 3, 4, 5, 6, 7, 8, 9};

    insn_sequencer_if #(.OPCODE_W(16)) bus();

    insn_sequencer #(
        .OPCODE_W (16),
        .TIMEOUT  (16),
        .TO_W     (5)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({bus.OpcodeAck, bus.ApInc, bus.ApDec, bus.DataInc, bus.DataDec,
                     bus.IoOutReq, bus.IoInReq, bus.Halted, bus.Fault, bus.FaultCode, bus.State});
    endfunction

    // Cycles from presenting an opcode (DUT in WAIT_OP) to the OpcodeAck cycle.
    // Counter ops: strobe 1 cycle after presentation, unit Ready returns lat
    // cycles after the strobe, but Ready is not honoured before WAIT_DONE.
    // IO ops: IoAck arrives lat cycles after the request rises.
    function automatic int exp_delay(input int idx, input int lat);
        case (idx)
            2, 3, 4, 7: return 1 + (((lat + 1) > 3) ? (lat + 1) : 3);
            8, 9:       return 1 + lat + 1;
            default:    return 2;
        endcase
    endfunction

    task automatic clr();
        n_dinc = 0; n_ddec = 0; n_ainc = 0; n_adec = 0;
        n_out = 0; n_in = 0; n_ack = 0; ack_cyc = -1; strobe_cyc = -1;
    endtask

    // Advance to the next falling edge, observe outputs, then update the models
    task automatic tick();
        @(negedge Clk);
        cyc++;
        if (bus.DataInc) n_dinc++;
        if (bus.DataDec) n_ddec++;
        if (bus.ApInc) n_ainc++;
        if (bus.ApDec) n_adec++;
        if (bus.IoOutReq) n_out++;
        if (bus.IoInReq) n_in++;
        if (bus.DataInc || bus.DataDec || bus.ApInc || bus.ApDec) strobe_cyc = cyc;
        if ((bus.IoOutReq || bus.IoInReq) && io_cnt == 0) strobe_cyc = cyc;
        if (bus.OpcodeAck) begin
            n_ack++;
            ack_cyc = cyc;
            bus.OpcodeReady = 1'b0;
        end
        if (bus.DataInc || bus.DataDec) data_busy = data_lat;
        else if (data_busy > 0) data_busy--;
        bus.DataReady = (data_busy == 0);
        if (bus.ApInc || bus.ApDec) ap_busy = ap_lat;
        else if (ap_busy > 0) ap_busy--;
        bus.ApReady = (ap_busy == 0);
        if (bus.IoOutReq || bus.IoInReq) begin
            bus.IoAck = (io_cnt == io_lat);
            io_cnt++;
        end else begin
            io_cnt = 0;
            bus.IoAck = 1'b0;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.OpcodeReady = 1'b0;
        bus.Step = 1'b0;
        data_busy = 0; ap_busy = 0; io_cnt = 0;
        bus.DataReady = 1'b1; bus.ApReady = 1'b1; bus.IoAck = 1'b0;
        tick();
        chk("rst_state", int'(bus.State), 0);
        Rst = 1'b0;
        tick();
        chk("post_rst_state", int'(bus.State), 1);
    endtask

    task automatic present(input int idx);
        bus.Opcode = '0;
        bus.Opcode[idx] = 1'b1;
        bus.OpcodeReady = 1'b1;
    endtask

    // One legal instruction under Run=1, checked against the opcode rules
    task automatic do_insn(input int idx, input int lat);
        int p;
        clr();
        data_lat = lat; ap_lat = lat; io_lat = lat;
        chk("pre_state", int'(bus.State), 1);
        p = cyc;
        present(idx);
        for (int k = 0; k < 400 && n_ack == 0; k++) tick();
        chk("ack_seen", n_ack, 1);
        chk("ack_delay", ack_cyc - p, exp_delay(idx, lat));
        chk("data_inc", n_dinc, (idx == 2) ? 1 : 0);
        chk("data_dec", n_ddec, (idx == 3) ? 1 : 0);
        chk("ap_inc", n_ainc, (idx == 4) ? 1 : 0);
        chk("ap_dec", n_adec, (idx == 7) ? 1 : 0);
        chk("io_out_cycles", n_out, (idx == 8) ? lat + 1 : 0);
        chk("io_in_cycles", n_in, (idx == 9) ? lat + 1 : 0);
        tick();
        tick();
        chk("ack_width", n_ack, 1);
    endtask

    initial begin
        int p, s, idx, bad;
        Rst = 1'b1;
        bus.Run = 1'b0; bus.Step = 1'b0; bus.Opcode = '0; bus.OpcodeReady = 1'b0;
        bus.ApReady = 1'b1; bus.DataReady = 1'b1; bus.IoAck = 1'b0;
        data_busy = 0; ap_busy = 0; io_cnt = 0; data_lat = 1; ap_lat = 1; io_lat = 1;
        clr();

        #2;
        chk("reset_outputs", outs_vec(), 0);
        tick();
        chk("reset_state_held", int'(bus.State), 0);
        Rst = 1'b0;
        tick();
        chk("idle_to_wait_op", int'(bus.State), 1);

        // '+' with DataReady low for 5 cycles after the strobe
        bus.Run = 1'b1;
        do_insn(2, 5);
        chk("plus_ack_after_strobe", ack_cyc - strobe_cyc, 6);

        // Randomized legal instruction stream
        for (int i = 0; i < 20; i++) begin
            idx = legal_ops[$urandom_range(0, 8)];
            do_insn(idx, int'($urandom_range(1, 8)));
        end

        // Run and Step together must not leave a pending step behind
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        bus.Run = 1'b0;
        tick();
        clr();
        present(2);
        repeat (10) tick();
        chk("run_step_no_leftover", n_dinc, 0);
        chk("run_step_state", int'(bus.State), 1);

        // Single-step two '>' instructions
        for (int j = 0; j < 2; j++) begin
            present(4);
            ap_lat = 2;
            clr();
            repeat (20) tick();
            chk("step_idle_strobe", n_ainc, 0);
            chk("step_idle_ack", n_ack, 0);
            bus.Step = 1'b1;
            s = cyc;
            tick();
            bus.Step = 1'b0;
            for (int k = 0; k < 100 && n_ack == 0; k++) tick();
            chk("step_strobe_cycle", strobe_cyc - s, 2);
            chk("step_ap_inc", n_ainc, 1);
            chk("step_ack", n_ack, 1);
            tick();
            tick();
        end

        // Two-bit opcode 0x0024 faults and stays faulted
        bus.Run = 1'b1;
        clr();
        bus.Opcode = 16'h0024;
        bus.OpcodeReady = 1'b1;
        tick();
        chk("illegal_dispatch_state", int'(bus.State), 2);
        tick();
        chk("illegal_fault", int'(bus.Fault), 1);
        chk("illegal_code", int'(bus.FaultCode), 2);
        chk("illegal_state", int'(bus.State), 7);
        chk("illegal_not_halted", int'(bus.Halted), 0);
        bus.Run = 1'b0;
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        bus.Run = 1'b1;
        present(2);
        repeat (15) tick();
        chk("fault_no_strobes", n_dinc + n_ddec + n_ainc + n_adec + n_out + n_in, 0);
        chk("fault_no_ack", n_ack, 0);
        chk("fault_sticky_code", int'(bus.FaultCode), 2);
        chk("fault_sticky_state", int'(bus.State), 7);

        // Other illegal forms: zero, random reserved bit, random pair of legal bits
        for (int j = 0; j < 3; j++) begin
            do_reset();
            clr();
            bus.Opcode = '0;
            if (j == 1) begin
                bad = int'($urandom_range(10, 15));
                bus.Opcode[bad] = 1'b1;
            end else if (j == 2) begin
                bad = int'($urandom_range(0, 8));
                bus.Opcode[bad] = 1'b1;
                bus.Opcode[bad + 1] = 1'b1;
            end
            bus.OpcodeReady = 1'b1;
            tick();
            tick();
            chk("illegal_kind_code", int'(bus.FaultCode), 2);
            chk("illegal_kind_strobes", n_dinc + n_ddec + n_ainc + n_adec + n_out + n_in, 0);
        end

        // '<' with ApReady stuck low trips the watchdog
        do_reset();
        clr();
        ap_lat = 1000;
        p = cyc;
        present(7);
        repeat (17) tick();
        chk("timeout_not_yet", int'(bus.Fault), 0);
        chk("timeout_wait_state", int'(bus.State), 4);
        tick();
        chk("timeout_fault", int'(bus.Fault), 1);
        chk("timeout_code", int'(bus.FaultCode), 1);
        chk("timeout_after_guard", cyc - (p + 2), 16);
        chk("timeout_single_strobe", n_adec, 1);
        chk("timeout_no_ack", n_ack, 0);

        // '.' with a slow IO acknowledge, then HALT
        do_reset();
        do_insn(8, 100);
        chk("io_no_fault", int'(bus.Fault), 0);
        do_insn(1, 1);
        chk("halted", int'(bus.Halted), 1);
        chk("halt_state", int'(bus.State), 7);
        present(2);
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        repeat (10) tick();
        chk("halt_single_ack", n_ack, 1);
        chk("halt_ignores_run", n_dinc, 0);
        chk("halt_no_fault", int'(bus.Fault), 0);

        // Asynchronous reset while '-' waits on the data line
        do_reset();
        data_lat = 50;
        present(3);
        repeat (5) tick();
        chk("minus_wait_state", int'(bus.State), 4);
        #2;
        Rst = 1'b1;
        bus.OpcodeReady = 1'b0;
        #1;
        chk("async_reset_outputs", outs_vec(), 0);
        data_busy = 0;
        tick();
        chk("async_reset_idle", int'(bus.State), 0);
        Rst = 1'b0;
        tick();
        chk("async_reset_wait_op", int'(bus.State), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
